// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
package shared_reg_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_RELEASE
    } arb_state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 8;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bundle: req/we/wdata in, grant/status/shared value out.
interface shared_reg_arbiter_if
    import shared_reg_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W
) ();
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0]             we;
    logic [NUM_REQ*DATA_W-1:0]      wdata;
    logic [NUM_REQ-1:0]             gnt;
    logic [idx_w(NUM_REQ)-1:0]      owner;
    logic                           busy;
    logic [DATA_W-1:0]              q;
    logic                           timeout;

    modport master (output req, we, wdata, input gnt, owner, busy, q, timeout);
    modport slave  (input req, we, wdata, output gnt, owner, busy, q, timeout);
endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit after last_i, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);
    logic [IDX_W-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_i) + i) % NUM_REQ);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end
endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter owning one shared DATA_W register written by the granted requester.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    shared_reg_arbiter_if.slave  bus
);
    localparam int IDX_W = idx_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 2) begin : g_cfg_err
        $error("shared_reg_arbiter: unsupported NUM_REQ/MAX_HOLD");
    end

    arb_state_t                    state_q, state_d;
    logic [NUM_REQ-1:0]            gnt_q, gnt_d;
    logic [IDX_W-1:0]              owner_q, owner_d;
    logic [IDX_W-1:0]              last_q, last_d;
    logic                          busy_q, busy_d;
    logic [DATA_W-1:0]             data_q, data_d;
    logic [NUM_REQ-1:0][DATA_W-1:0] wslice;
    logic                          pick_found;
    logic [IDX_W-1:0]              pick_idx;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = idx_w(MAX_HOLD);
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;
`endif

    assign wslice = bus.wdata;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req_i   (bus.req),
        .last_i  (last_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        busy_d  = busy_q;
        data_d  = data_q;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ARB_GRANT: begin
                // Dropping req releases immediately; a write in that cycle is discarded.
                if (!bus.req[owner_q]) begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    last_d  = owner_q;
                end else begin
                    if (bus.we[owner_q])
                        data_d = wslice[owner_q];
`ifdef ARB_TIMEOUT_EN
                    if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                        state_d   = ARB_IDLE;
                        gnt_d     = '0;
                        busy_d    = 1'b0;
                        last_d    = owner_q;
                        timeout_d = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = ARB_IDLE;
                if (pick_found) begin
                    state_d           = ARB_GRANT;
                    owner_d           = pick_idx;
                    gnt_d             = '0;
                    gnt_d[pick_idx]   = 1'b1;
                    busy_d            = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_d            = '0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            busy_q  <= 1'b0;
            data_q  <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;
    assign bus.q     = data_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: vector table plus reset/rotation/hold sequences.
module tb_shared_reg_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;

    shared_reg_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

    shared_reg_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic [1:0]  owner;
        logic        busy;
        logic [7:0]  q;
    } vec_t;

    vec_t tbl [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus.req   = '0;
        bus.we    = '0;
        bus.wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        //            req      we       wdata          gnt      own  busy q
        tbl[0]  = '{4'b0001, 4'b0001, 32'h000000A5, 4'b0001, 2'd0, 1'b1, 8'h00};
        tbl[1]  = '{4'b0001, 4'b0001, 32'h000000A5, 4'b0001, 2'd0, 1'b1, 8'hA5};
        tbl[2]  = '{4'b0001, 4'b0000, 32'h00000011, 4'b0001, 2'd0, 1'b1, 8'hA5};
        tbl[3]  = '{4'b0101, 4'b0100, 32'h00FF0000, 4'b0001, 2'd0, 1'b1, 8'hA5};
        tbl[4]  = '{4'b0100, 4'b0101, 32'h00FF0022, 4'b0000, 2'd0, 1'b0, 8'hA5};
        tbl[5]  = '{4'b0100, 4'b0100, 32'h00770000, 4'b0100, 2'd2, 1'b1, 8'hA5};
        tbl[6]  = '{4'b0100, 4'b0100, 32'h00770000, 4'b0100, 2'd2, 1'b1, 8'h77};
        tbl[7]  = '{4'b0000, 4'b0000, 32'h00000000, 4'b0000, 2'd2, 1'b0, 8'h77};
        tbl[8]  = '{4'b0000, 4'b0001, 32'h00000099, 4'b0000, 2'd2, 1'b0, 8'h77};
        tbl[9]  = '{4'b1001, 4'b0000, 32'h00000000, 4'b1000, 2'd3, 1'b1, 8'h77};
        tbl[10] = '{4'b1001, 4'b0000, 32'h00000000, 4'b1000, 2'd3, 1'b1, 8'h77};
        tbl[11] = '{4'b0001, 4'b0000, 32'h00000000, 4'b0000, 2'd3, 1'b0, 8'h77};
        tbl[12] = '{4'b0001, 4'b0001, 32'h0000005A, 4'b0001, 2'd0, 1'b1, 8'h77};
        tbl[13] = '{4'b0001, 4'b0001, 32'h0000005A, 4'b0001, 2'd0, 1'b1, 8'h5A};
        tbl[14] = '{4'b0000, 4'b0000, 32'h00000000, 4'b0000, 2'd0, 1'b0, 8'h5A};
        tbl[15] = '{4'b0110, 4'b0100, 32'h00FF0000, 4'b0010, 2'd1, 1'b1, 8'h5A};
        tbl[16] = '{4'b0110, 4'b0100, 32'h00FF0000, 4'b0010, 2'd1, 1'b1, 8'h5A};
        tbl[17] = '{4'b0100, 4'b0100, 32'h00FF0000, 4'b0000, 2'd1, 1'b0, 8'h5A};
        tbl[18] = '{4'b0100, 4'b0100, 32'h00FF0000, 4'b0100, 2'd2, 1'b1, 8'h5A};
        tbl[19] = '{4'b0000, 4'b0100, 32'h00FF0000, 4'b0000, 2'd2, 1'b0, 8'h5A};

        do_reset();
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_owner", 32'(bus.owner), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_q", 32'(bus.q), 32'h0);
        check("rst_timeout", 32'(bus.timeout), 32'h0);

        for (int i = 0; i < 20; i++) begin
            bus.req   = tbl[i].req;
            bus.we    = tbl[i].we;
            bus.wdata = tbl[i].wdata;
            step();
            check($sformatf("v%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
            check($sformatf("v%0d_owner", i), 32'(bus.owner), 32'(tbl[i].owner));
            check($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
            check($sformatf("v%0d_q", i), 32'(bus.q), 32'(tbl[i].q));
        end

        // Rotation: all request, each releases after two grant cycles, then re-requests.
        do_reset();
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int e;
            e = k % 4;
            step();
            check($sformatf("rot%0d_gnt", k), 32'(bus.gnt), 32'(1) << e);
            check($sformatf("rot%0d_owner", k), 32'(bus.owner), 32'(e));
            step();
            check($sformatf("rot%0d_gnt2", k), 32'(bus.gnt), 32'(1) << e);
            bus.req[e] = 1'b0;
            step();
            check($sformatf("rot%0d_gap", k), 32'(bus.gnt), 32'h0);
            bus.req[e] = 1'b1;
        end
        bus.req = '0;

        // Asynchronous reset in the middle of a grant.
        do_reset();
        bus.req   = 4'b0001;
        bus.we    = 4'b0001;
        bus.wdata = 32'h0000003C;
        step();
        step();
        check("mid_q_before", 32'(bus.q), 32'h3C);
        check("mid_gnt_before", 32'(bus.gnt), 32'h1);
        reset = 1'b1;
        #1;
        check("mid_rst_gnt", 32'(bus.gnt), 32'h0);
        check("mid_rst_busy", 32'(bus.busy), 32'h0);
        check("mid_rst_q", 32'(bus.q), 32'h0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.req   = 4'b1000;
        bus.we    = '0;
        bus.wdata = '0;
        step();
        check("mid_after_gnt", 32'(bus.gnt), 32'h8);
        check("mid_after_owner", 32'(bus.owner), 32'h3);

        do_reset();
`ifdef ARB_TIMEOUT_EN
        begin
            int hi_cnt;
            int to_cnt;
            hi_cnt = 0;
            to_cnt = 0;
            bus.req = 4'b1100;
            step();
            for (int i = 0; i < 12; i++) begin
                if (bus.gnt == 4'b1000) break;
                if (bus.gnt == 4'b0100) hi_cnt++;
                if (bus.timeout) to_cnt++;
                step();
            end
            check("to_hold_cycles", 32'(hi_cnt), 32'd4);
            check("to_pulses", 32'(to_cnt), 32'd1);
            check("to_next_gnt", 32'(bus.gnt), 32'h8);
        end
`else
        bus.req = 4'b0001;
        for (int i = 0; i < 100; i++) begin
            step();
            check($sformatf("hold%0d_gnt", i), 32'(bus.gnt), 32'h1);
            check($sformatf("hold%0d_timeout", i), 32'(bus.timeout), 32'h0);
        end
`endif
        bus.req = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter that shares one DATA_W-bit D-flip-flop storage register among NUM_REQ requesters.
- Each requester gets exclusive write access through a req/gnt handshake. The stored value is visible to all requesters on q.
- Sits between lab-level requester logic (switch inputs, counters, FSMs) and the shared register.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, width of the shared register and of each write-data slice
- MAX_HOLD, 16, maximum consecutive grant cycles per ownership; used only with timeout feature (>=2)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req  input  NUM_REQ  per-requester access request, level, held until done
- we  input  NUM_REQ  per-requester write strobe; honoured only for current owner while granted
- wdata  input  NUM_REQ*DATA_W  write data; requester i uses bits [i*DATA_W +: DATA_W]
- gnt  output  NUM_REQ  one-hot grant, registered
- owner  output  $clog2(NUM_REQ)  index of current/last owner
- busy  output  1  high while any grant is active
- q  output  DATA_W  shared register contents
- timeout  output  1  one-cycle pulse on forced release (feature only; tied 0 otherwise)

Behaviour:
- Reset is asynchronous and active-high; clock is clk; all state changes on rising edge.
- Reset values: q=0, gnt=0, owner=0, busy=0, timeout=0, state=IDLE, rr pointer last=NUM_REQ-1, hold_cnt=0. Requester 0 has first priority after reset.
- FSM states:
  - IDLE: gnt=0. If any req bit is set at an edge, pick the first set bit searching last+1, last+2, ... with wrap at NUM_REQ. Register the winner into owner, set gnt[owner]=1, busy=1, go to GRANT.
  - GRANT: while req[owner]=1 and we[owner]=1, q <= wdata slice of owner at every edge. If we[owner]=0, q holds.
  - Release from GRANT: when req[owner] is sampled 0, the next state is IDLE with gnt=0, busy=0 and last<=owner. Any write requested in that cycle is ignored.
  - RELEASE is a one-cycle turnaround: GRANT -> IDLE always spends at least one cycle with gnt=0 before the next grant.
- Latency:
  - req sampled at edge n -> gnt high after edge n (visible in cycle n+1).
  - First write lands at the edge that ends the first gnt cycle; q updates 2 edges after req rises if we is already high.
- Non-owner we/wdata are ignored at all times. A write with no grant never changes q.
- Simultaneous requests: strict rotation, so every active requester is granted within NUM_REQ grants (no starvation).
- req dropped and re-raised by the same requester: after the idle cycle it is arbitrated again, now at lowest priority.
- Reset mid-grant: gnt, busy and q clear immediately (asynchronous). The in-flight write is lost. Arbitration restarts at requester 0.
- owner holds its last value in IDLE.

Optional Feature:
- Macro: ARB_TIMEOUT_EN
- Defined:
  - hold_cnt increments each GRANT cycle.
  - When hold_cnt reaches MAX_HOLD-1 and req[owner] is still 1, force release to IDLE, pulse timeout for one cycle and advance last<=owner.
  - hold_cnt clears on entry to GRANT.
- Undefined: no counter, grant held indefinitely, timeout tied 0.

Decomposition:
- Package shared_reg_pkg holds:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_GRANT, ARB_RELEASE}
  - localparam defaults for NUM_REQ/DATA_W
  - function clog2-safe index width
- Sub-module rr_pick (combinational): inputs req and last pointer, outputs found flag and winner index. Instantiated once.

Test Plan:
- Reset then req=4'b0001, we=1, wdata0=8'hA5 -> gnt=4'b0001 one cycle after req, q=8'hA5 the following cycle, owner=0, busy=1.
- req=4'b1111 held, each requester drops req after 2 grant cycles -> grant order 0,1,2,3,0, each separated by one gnt=0 cycle.
- Owner 1 granted with we[1]=0; requester 2 drives we[2]=1, wdata2=8'hFF -> q unchanged.
- Assert reset during GRANT with q=8'h3C -> gnt=0, busy=0, q=8'h00 immediately; next req=4'b1000 is granted to requester 3.
- ARB_TIMEOUT_EN defined, MAX_HOLD=4, req[2] held high -> gnt[2] high exactly 4 cycles, timeout pulses once, requester 3 granted next if requesting.
- ARB_TIMEOUT_EN undefined, req[0] held 100 cycles -> gnt[0] stays high throughout, timeout stays 0.
